arb_out_buffer: RTL and testbench

ARB_OUT_BUFFER -- requirements
Module: arb_out_buffer

---
 rtl/arb_out_buffer.sv | 110 +++++++++++
 tb/tb_arb_out_buffer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/arb_out_buffer.sv
// Output buffer between the readout arbiter and the downstream SRAM/USB FIFO
// stage. First-word-fall-through FIFO of 2**DEPTH_BITS 32-bit words with
// registered back-pressure, a near-full flag, an accepted-word counter and a
// saturating counter of writes dropped because the buffer was full.
module arb_out_buffer #(
    parameter int DEPTH_BITS          = 4,
    parameter int NEAR_FULL_THRESHOLD = 12
) (
    input  logic        BUS_CLK,
    input  logic        BUS_RST,
    input  logic        WRITE_IN,
    input  logic [31:0] DATA_IN,
    output logic        READY_OUT,
    input  logic        FIFO_READ,
    output logic        FIFO_EMPTY,
    output logic [31:0] FIFO_DATA,
    output logic        NEAR_FULL,
    output logic [15:0] WORD_COUNT,
    output logic [7:0]  LOST_COUNT
);

    localparam int                  DEPTH    = 1 << DEPTH_BITS;
    localparam logic [DEPTH_BITS:0] OCC_FULL = (DEPTH_BITS + 1)'(DEPTH);
    localparam logic [DEPTH_BITS:0] OCC_NEAR = (DEPTH_BITS + 1)'(NEAR_FULL_THRESHOLD);

    // Storage and control state
    logic [31:0]           mem_q [DEPTH];
    logic [DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_BITS:0]   occ_q, occ_d;
    logic [15:0]           word_count_q, word_count_d;
    logic [7:0]            lost_count_q, lost_count_d;

    logic wr_en;
    logic rd_en;
    logic wr_drop;

    // Flags come straight from the occupancy register, so READY_OUT never
    // depends on FIFO_READ in the same cycle.
    assign READY_OUT  = (occ_q < OCC_FULL);
    assign FIFO_EMPTY = (occ_q == '0);
    assign NEAR_FULL  = (occ_q >= OCC_NEAR);
    assign FIFO_DATA  = mem_q[rd_ptr_q];
    assign WORD_COUNT = word_count_q;
    assign LOST_COUNT = lost_count_q;

    assign wr_en   = WRITE_IN && READY_OUT;
    assign wr_drop = WRITE_IN && !READY_OUT;
    assign rd_en   = FIFO_READ && !FIFO_EMPTY;

    // Next-state computation for pointers, occupancy and statistics counters
    always_comb begin
        // NOTE: every next-state signal gets a default first, so no path leaves
        // it unassigned and no latch is inferred.
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        occ_d        = occ_q;
        word_count_d = word_count_q;
        lost_count_d = lost_count_q;

        if (wr_en) begin
            wr_ptr_d     = wr_ptr_q + 1'b1;
            word_count_d = word_count_q + 1'b1;
        end

        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        // A full buffer can still be read in the cycle a write is dropped.
        if (wr_drop && (lost_count_q != 8'hFF)) begin
            lost_count_d = lost_count_q + 1'b1;
        end

        case ({wr_en, rd_en})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
    end

    // Control state register with synchronous reset
    always_ff @(posedge BUS_CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge value of every other register.
        if (BUS_RST) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            occ_q        <= '0;
            word_count_q <= '0;
            lost_count_q <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            occ_q        <= occ_d;
            word_count_q <= word_count_d;
            lost_count_q <= lost_count_d;
        end
    end

    // Word storage written at the write pointer on an accepted write
    always_ff @(posedge BUS_CLK) begin
        // NOTE: the storage array has no reset; clearing the pointers and the
        // occupancy is enough to discard its contents, and it maps to RAM.
        if (wr_en && !BUS_RST) begin
            mem_q[wr_ptr_q] <= DATA_IN;
        end
    end

endmodule

// File: tb/tb_arb_out_buffer.sv
// Self-checking bench for arb_out_buffer. A transaction-level model (word
// queue plus occupancy and counter integers) predicts every output; a monitor
// compares status flags each cycle and pops the scoreboard on every read.
module tb_arb_out_buffer;

    localparam int DEPTH = 16;
    localparam int THR   = 12;

    logic        BUS_CLK = 1'b0;
    logic        BUS_RST;
    logic        WRITE_IN;
    logic [31:0] DATA_IN;
    logic        READY_OUT;
    logic        FIFO_READ;
    logic        FIFO_EMPTY;
    logic [31:0] FIFO_DATA;
    logic        NEAR_FULL;
    logic [15:0] WORD_COUNT;
    logic [7:0]  LOST_COUNT;

    arb_out_buffer dut (
        .BUS_CLK    (BUS_CLK),
        .BUS_RST    (BUS_RST),
        .WRITE_IN   (WRITE_IN),
        .DATA_IN    (DATA_IN),
        .READY_OUT  (READY_OUT),
        .FIFO_READ  (FIFO_READ),
        .FIFO_EMPTY (FIFO_EMPTY),
        .FIFO_DATA  (FIFO_DATA),
        .NEAR_FULL  (NEAR_FULL),
        .WORD_COUNT (WORD_COUNT),
        .LOST_COUNT (LOST_COUNT)
    );

    always #5 BUS_CLK = ~BUS_CLK;

    // Reference model state
    logic [31:0] exp_q[$];
    int          m_occ;
    int          m_wc;
    int          m_lc;
    bit          model_ok = 1'b0;

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, let the edge happen, then advance the model.
    task automatic cycle(input bit rst, input bit w, input logic [31:0] d, input bit r);
        bit wr_ok;
        bit rd_ok;
        BUS_RST   = rst;
        WRITE_IN  = w;
        DATA_IN   = d;
        FIFO_READ = r;
        @(posedge BUS_CLK);
        #1;
        if (rst) begin
            m_occ    = 0;
            m_wc     = 0;
            m_lc     = 0;
            exp_q.delete();
            model_ok = 1'b1;
        end else begin
            wr_ok = w && (m_occ < DEPTH);
            rd_ok = r && (m_occ > 0);
            if (w && !wr_ok) m_lc = (m_lc >= 255) ? 255 : m_lc + 1;
            if (wr_ok) begin
                exp_q.push_back(d);
                m_wc = (m_wc + 1) % 65536;
            end
            m_occ = m_occ + int'(wr_ok) - int'(rd_ok);
        end
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic reset_dut();
        cycle(1'b1, 1'b1, $urandom, 1'b1);
    endtask

    // Monitor: status flags every cycle, head-of-queue data, scoreboard pop on read
    initial begin
        forever begin
            @(negedge BUS_CLK);
            if (model_ok && !BUS_RST) begin
                check("ready_out",  32'(READY_OUT),  32'(m_occ < DEPTH));
                check("fifo_empty", 32'(FIFO_EMPTY), 32'(m_occ == 0));
                check("near_full",  32'(NEAR_FULL),  32'(m_occ >= THR));
                check("word_count", 32'(WORD_COUNT), 32'(m_wc));
                check("lost_count", 32'(LOST_COUNT), 32'(m_lc));
                if (m_occ > 0) check("head_data", FIFO_DATA, exp_q[0]);
                if (FIFO_READ && !FIFO_EMPTY) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fails++;
                        $display("FAIL read_data: DUT read 0x%08h, scoreboard empty", FIFO_DATA);
                    end else begin
                        check("read_data", FIFO_DATA, exp_q.pop_front());
                    end
                end
            end
        end
    end

    // Stimulus
    initial begin
        int pw;
        int pr;

        reset_dut();
        reset_dut();
        check("rst_ready", 32'(READY_OUT), 32'd1);
        check("rst_empty", 32'(FIFO_EMPTY), 32'd1);
        check("rst_near",  32'(NEAR_FULL), 32'd0);
        check("rst_wc",    32'(WORD_COUNT), 32'd0);
        check("rst_lc",    32'(LOST_COUNT), 32'd0);

        // Single word into an empty buffer, then read it out
        cycle(1'b0, 1'b1, 32'hDEADBEEF, 1'b0);
        check("one_empty", 32'(FIFO_EMPTY), 32'd0);
        check("one_data",  FIFO_DATA, 32'hDEADBEEF);
        check("one_wc",    32'(WORD_COUNT), 32'd1);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        check("one_drained", 32'(FIFO_EMPTY), 32'd1);

        // Read of an empty buffer changes nothing; write with read into empty stores
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        cycle(1'b0, 1'b1, 32'hA5A5_0001, 1'b1);
        check("wr_rd_empty", 32'(FIFO_EMPTY), 32'd0);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);

        // Fill to full, then one dropped write
        reset_dut();
        for (int i = 1; i <= 17; i++) begin
            cycle(1'b0, 1'b1, 32'(i), 1'b0);
            check("fill_near",  32'(NEAR_FULL), 32'(((i > 16) ? 16 : i) >= THR));
            check("fill_ready", 32'(READY_OUT), 32'(i < 16));
        end
        check("fill_lc", 32'(LOST_COUNT), 32'd1);
        check("fill_wc", 32'(WORD_COUNT), 32'd16);

        // Full: write and read together -> write dropped, one word leaves
        cycle(1'b0, 1'b1, 32'hBAD0_BAD0, 1'b1);
        check("full_rw_lc",    32'(LOST_COUNT), 32'd2);
        check("full_rw_ready", 32'(READY_OUT), 32'd1);
        check("full_rw_wc",    32'(WORD_COUNT), 32'd16);
        for (int i = 0; i < 16; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1);
        check("drain_empty", 32'(FIFO_EMPTY), 32'd1);

        // Streaming at half occupancy across pointer wrap
        reset_dut();
        for (int v = 0; v < 8; v++) cycle(1'b0, 1'b1, 32'(v), 1'b0);
        for (int v = 8; v < 100; v++) begin
            cycle(1'b0, 1'b1, 32'(v), 1'b1);
            check("stream_head", FIFO_DATA, 32'(v - 7));
        end
        for (int v = 0; v < 8; v++) cycle(1'b0, 1'b0, 32'h0, 1'b1);

        // LOST_COUNT saturation
        reset_dut();
        for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, $urandom, 1'b0);
        for (int i = 0; i < 300; i++) cycle(1'b0, 1'b1, $urandom, 1'b0);
        check("lost_sat", 32'(LOST_COUNT), 32'd255);

        // WORD_COUNT wrap after 65537 accepted writes with draining
        reset_dut();
        for (int i = 0; i < 65537; i++) cycle(1'b0, 1'b1, $urandom, 1'b1);
        check("wc_wrap", 32'(WORD_COUNT), 32'd1);

        // Reset with 8 words stored
        reset_dut();
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 32'hC000_0000 + 32'(i), 1'b0);
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        check("mid_rst_empty", 32'(FIFO_EMPTY), 32'd1);
        check("mid_rst_ready", 32'(READY_OUT), 32'd1);
        check("mid_rst_wc",    32'(WORD_COUNT), 32'd0);
        check("mid_rst_lc",    32'(LOST_COUNT), 32'd0);
        cycle(1'b0, 1'b1, 32'h1234_5678, 1'b0);
        check("mid_rst_new", FIFO_DATA, 32'h1234_5678);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        check("mid_rst_after", 32'(FIFO_EMPTY), 32'd1);

        // Randomized traffic with phases biased toward full and toward empty
        for (int ph = 0; ph < 12; ph++) begin
            pw = $urandom_range(95, 5);
            pr = $urandom_range(95, 5);
            for (int i = 0; i < 250; i++) begin
                cycle(($urandom_range(999) == 0), ($urandom_range(99) < pw), $urandom,
                      ($urandom_range(99) < pr));
            end
        end
        while (m_occ > 0) cycle(1'b0, 1'b0, 32'h0, 1'b1);
        idle();
        check("final_empty", 32'(FIFO_EMPTY), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
